// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction fetch stage.
// IFETCH_PERF_CNT_EN enables the delivered-instruction counter.
package ifetch_pkg;

  localparam int PC_WIDTH   = 32;
  localparam int INST_WIDTH = 32;
  localparam int BUF_DEPTH  = 2;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

`ifdef IFETCH_PERF_CNT_EN
  localparam bit PERF_CNT_EN = 1'b1;
`else
  localparam bit PERF_CNT_EN = 1'b0;
`endif

endpackage

// File: rtl/ifetch_buffer.sv
// Synchronous FIFO holding {instruction, pc} entries between the bus and the decoder.
// Flush empties it in one cycle; push and pop may coincide even when full.
module ifetch_buffer #(
  parameter int width = 64,
  parameter int depth = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [width-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [width-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth):0]     count
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == cw'(depth));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; only pointers and count need a known value.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + aw'(1);
      if (do_pop)  rd_ptr <= rd_ptr + aw'(1);
      count <= count + cw'(do_push) - cw'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, issues word-aligned reads, buffers responses
// for the decoder and restarts on redirect. IFETCH_PERF_CNT_EN adds fetch_count.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int                  pc_width   = PC_WIDTH,
  parameter int                  inst_width = INST_WIDTH,
  parameter logic [pc_width-1:0] pc_init    = pc_width'(RESET_VECTOR),
  parameter int                  buf_depth  = BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [pc_width-1:0]   ir_addr,
  output logic                  ir_addr_valid,
  input  logic                  ir_addr_ready,
  input  logic [inst_width-1:0] ir_data,
  input  logic                  ir_data_valid,
  output logic                  ir_data_ready,
  input  logic                  redirect,
  input  logic [pc_width-1:0]   redirect_pc,
  output logic [inst_width-1:0] inst,
  output logic [pc_width-1:0]   inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_count
`endif
);

  localparam int cnt_w = $clog2(buf_depth) + 1;
  localparam int ent_w = inst_width + pc_width;

  logic [pc_width-1:0] pc;
  logic [pc_width-1:0] resp_pc;
  logic [pc_width-1:0] target_pc;
  logic [cnt_w-1:0]    outstanding;
  logic [cnt_w-1:0]    outstanding_nxt;
  logic [cnt_w-1:0]    discard;
  logic [cnt_w-1:0]    buf_count;
  logic [cnt_w:0]      in_use;
  logic                buf_full;
  logic                buf_empty;
  logic                req_fire;
  logic                resp;
  logic                resp_keep;
  logic                pop;
  logic [ent_w-1:0]    head;

  assign ir_addr       = pc;
  assign ir_data_ready = 1'b1;
  assign target_pc     = redirect_pc & ~pc_width'(3);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    in_use          = {1'b0, outstanding} + {1'b0, buf_count};
    ir_addr_valid   = !redirect && (in_use < (cnt_w + 1)'(buf_depth));
    req_fire        = ir_addr_valid && ir_addr_ready;
    resp            = ir_data_valid && (outstanding != '0);
    resp_keep       = resp && (discard == '0) && !redirect;
    pop             = inst_valid && inst_ready && !redirect;
    outstanding_nxt = outstanding + cnt_w'(req_fire) - cnt_w'(resp);
  end

  // Between redirects requests are sequential, so the next kept response is always resp_pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= pc_init;
      resp_pc     <= pc_init;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        pc      <= target_pc;
        resp_pc <= target_pc;
        discard <= outstanding_nxt;
      end else begin
        if (req_fire)                 pc      <= pc + pc_width'(4);
        if (resp_keep)                resp_pc <= resp_pc + pc_width'(4);
        if (resp && discard != '0)    discard <= discard - cnt_w'(1);
      end
    end
  end

  ifetch_buffer #(
    .width (ent_w),
    .depth (buf_depth)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (resp_keep),
    .push_data ({ir_data, resp_pc}),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign inst       = head[ent_w-1:pc_width];
  assign inst_pc    = head[pc_width-1:0];
  assign inst_valid = !buf_empty;

  // A response without a request, or a push into a full buffer without a pop, is a bus error.
  always_ff @(posedge clk) begin
    if (!rst && ir_data_valid)
      assert (outstanding != '0) else $error("ifetch: response with no outstanding request");
    if (!rst && resp_keep)
      assert (!buf_full || pop) else $error("ifetch: instruction buffer overrun");
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)      fetch_count <= '0;
    else if (pop) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios then randomized bus/decoder traffic,
// checked every cycle against a request/response reference model.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] PC_INIT = 32'h0;

  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] pc; bit stale; } fly_t;
  typedef struct { logic [31:0] addr; int due; } bus_t;

  logic        clk, rst;
  logic [31:0] ir_addr;
  logic        ir_addr_valid, ir_addr_ready;
  logic [31:0] ir_data;
  logic        ir_data_valid, ir_data_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, inst_ready;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int n_checks, n_errors;
  int cyc, n_deliv, first_acc, first_val;
  int rdy_mode, ird_mode, min_lat, max_lat;
  logic [31:0] m_pc;
  int          m_delivered;
  ent_t        m_q[$];
  fly_t        m_fly[$];
  bus_t        bus_q[$];
  logic [31:0] dut_log[$];

  ifetch #(
    .pc_width   (32),
    .inst_width (32),
    .pc_init    (PC_INIT),
    .buf_depth  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ir_addr       (ir_addr),
    .ir_addr_valid (ir_addr_valid),
    .ir_addr_ready (ir_addr_ready),
    .ir_data       (ir_data),
    .ir_data_valid (ir_data_valid),
    .ir_data_ready (ir_data_ready),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc        = PC_INIT;
    m_delivered = 0;
    n_deliv     = 0;
    first_acc   = -1;
    first_val   = -1;
    m_q.delete();
    m_fly.delete();
    bus_q.delete();
    dut_log.delete();
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then advance model and bus.
  task automatic step(input bit do_redir, input logic [31:0] tgt, input bit do_rst);
    bit   rsp, exp_av, exp_iv, take;
    fly_t f;
    @(negedge clk);
    rst         = do_rst;
    redirect    = do_redir && !do_rst;
    redirect_pc = tgt;
    case (rdy_mode)
      0:       ir_addr_ready = 1'b1;
      1:       ir_addr_ready = 1'b0;
      default: ir_addr_ready = ($urandom_range(0, 3) != 0);
    endcase
    rsp           = !do_rst && bus_q.size() > 0 && bus_q[0].due <= cyc;
    ir_data_valid = rsp;
    ir_data       = rsp ? mem_word(bus_q[0].addr) : $urandom();
    case (ird_mode)
      0:       inst_ready = 1'b1;
      1:       inst_ready = 1'b0;
      default: inst_ready = ($urandom_range(0, 2) != 0);
    endcase
    if (redirect) inst_ready = 1'b0;
    #1;

    exp_av = !redirect && (m_fly.size() + m_q.size() < DEPTH);
    exp_iv = (m_q.size() != 0);
    check("ir_addr_valid", 32'(ir_addr_valid), 32'(exp_av));
    if (exp_av) check("ir_addr", ir_addr, m_pc);
    check("inst_valid", 32'(inst_valid), 32'(exp_iv));
    if (exp_iv) begin
      check("inst_pc", inst_pc, m_q[0].pc);
      check("inst", inst, m_q[0].data);
    end
    check("ir_data_ready", 32'(ir_data_ready), 32'd1);
`ifdef IFETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, 32'(m_delivered));
`endif

    if (rst) begin
      model_reset();
    end else begin
      if (first_acc < 0 && ir_addr_valid && ir_addr_ready) first_acc = cyc;
      if (first_val < 0 && inst_valid) first_val = cyc;
      if (inst_valid && inst_ready && !redirect) begin
        n_deliv++;
        dut_log.push_back(inst_pc);
      end
      if (rsp) bus_q.delete(0);
      if (ir_addr_valid && ir_addr_ready)
        bus_q.push_back('{ir_addr, cyc + 1 + min_lat + int'($urandom_range(0, max_lat))});

      take = 1'b0;
      if (rsp && m_fly.size() != 0) begin
        f = m_fly.pop_front();
        take = !f.stale;
      end
      if (redirect) begin
        foreach (m_fly[i]) m_fly[i].stale = 1'b1;
        m_q.delete();
        m_pc = tgt & ~32'h3;
      end else begin
        if (exp_iv && inst_ready) begin
          m_q.delete(0);
          m_delivered++;
        end
        if (take) m_q.push_back('{f.pc, mem_word(f.pc)});
        if (exp_av && ir_addr_ready) begin
          m_fly.push_back('{m_pc, 1'b0});
          m_pc += 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    int  gaps, r;
    bit  found;
    n_checks = 0; n_errors = 0; cyc = 0;
    rdy_mode = 0; ird_mode = 0; min_lat = 0; max_lat = 0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    ir_addr_ready = 1'b0; ir_data_valid = 1'b0; ir_data = '0; inst_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // 1: zero-wait bus from reset
    repeat (10) step(1'b0, 32'h0, 1'b0);
    check("t1_latency", 32'(first_val - first_acc), 32'd2);
    check("t1_enough", 32'(dut_log.size() >= 3), 32'd1);
    if (dut_log.size() >= 3) begin
      check("t1_pc0", dut_log[0], 32'h0);
      check("t1_pc1", dut_log[1], 32'h4);
      check("t1_pc2", dut_log[2], 32'h8);
    end

    // 2: decoder stalls, buffer fills, then drains without loss
    do_reset();
    ird_mode = 1;
    repeat (5) step(1'b0, 32'h0, 1'b0);
    check("t2_inst_valid", 32'(inst_valid), 32'd1);
    check("t2_addr_blocked", 32'(ir_addr_valid), 32'd0);
    ird_mode = 0;
    repeat (10) step(1'b0, 32'h0, 1'b0);
    gaps = 0;
    for (int i = 1; i < dut_log.size(); i++)
      if (dut_log[i] != dut_log[i-1] + 32'd4) gaps++;
    check("t2_no_gaps", 32'(gaps), 32'd0);
    check("t2_first", (dut_log.size() > 0) ? dut_log[0] : 32'hDEAD_BEEF, PC_INIT);

    // 3: bus stall holds the request at 0x8
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 32'h0, 1'b0);
      found = (m_pc == 32'h8);
    end
    check("t3_reached", 32'(found), 32'd1);
    rdy_mode = 1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0);
      check("t3_addr_stable", ir_addr, 32'h8);
    end
    rdy_mode = 0;
    step(1'b0, 32'h0, 1'b0);
    check("t3_addr_resume", ir_addr, 32'h8);

    // 4: redirect with two responses outstanding
    do_reset();
    min_lat = 4;
    for (int i = 0; i < 10 && bus_q.size() < 2; i++) step(1'b0, 32'h0, 1'b0);
    check("t4_outstanding", 32'(bus_q.size()), 32'd2);
    step(1'b1, 32'h100, 1'b0);
    min_lat = 0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, 32'h0, 1'b0);
      found = inst_valid;
    end
    check("t4_valid", 32'(found), 32'd1);
    check("t4_pc", inst_pc, 32'h100);
    check("t4_inst", inst, mem_word(32'h100));

    // 5: misaligned redirect coincident with a response
    do_reset();
    min_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus_q.size() > 0 && bus_q[0].due <= cyc) found = 1'b1;
      else step(1'b0, 32'h0, 1'b0);
    end
    check("t5_resp_pending", 32'(found), 32'd1);
    step(1'b1, 32'h103, 1'b0);
    check("t5_resp_seen", 32'(ir_data_valid), 32'd1);
    min_lat = 0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, 32'h0, 1'b0);
      found = inst_valid;
    end
    check("t5_valid", 32'(found), 32'd1);
    check("t5_pc", inst_pc, 32'h100);
    check("t5_inst", inst, mem_word(32'h100));

`ifdef IFETCH_PERF_CNT_EN
    // 6: ten deliveries across a redirect
    do_reset();
    ird_mode = 2;
    found = 1'b0;
    for (int i = 0; i < 200 && n_deliv < 10; i++) begin
      if (n_deliv == 5 && !found) begin
        step(1'b1, 32'h40, 1'b0);
        found = 1'b1;
      end else begin
        step(1'b0, 32'h0, 1'b0);
      end
    end
    ird_mode = 1;
    step(1'b0, 32'h0, 1'b0);
    check("t6_redirected", 32'(found), 32'd1);
    check("t6_fetch_count", fetch_count, 32'd10);
`endif

    // Random traffic: bus back-pressure, variable latency, redirects and resets
    do_reset();
    rdy_mode = 2; ird_mode = 2; min_lat = 0; max_lat = 3;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 399));
      if (r == 0)       step(1'b0, 32'h0, 1'b1);
      else if (r < 14)  step(1'b1, $urandom(), 1'b0);
      else              step(1'b0, 32'h0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
